// File: rtl/pwm_duty_scheduler_pkg.sv
// ============================================================================
// pwm_duty_scheduler_pkg : scheduler state encoding and default geometry
// Revision 1.0
// ============================================================================
`default_nettype none

package pwm_duty_scheduler_pkg;

  localparam int unsigned DEFAULT_DUTY_W    = 4;
  localparam int unsigned DEFAULT_PERIOD    = 16;
  localparam int unsigned DEFAULT_RAMP_STEP = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_STOP = 2'd2
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_duty_scheduler_frame_timer.sv
// ============================================================================
// pwm_duty_scheduler_frame_timer : free-running PWM frame counter
// Revision 1.0
// ============================================================================
`default_nettype none

module pwm_duty_scheduler_frame_timer
  import pwm_duty_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD = DEFAULT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  output logic bnd,
  output logic frame_start
);

  localparam int unsigned     CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_start_q, frame_start_d;

  // frame_start is registered from bnd so it is high exactly while cnt == 0
  always_comb begin
    bnd           = (cnt_q == LAST);
    cnt_d         = bnd ? '0 : cnt_q + CNT_W'(1);
    frame_start_d = bnd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: rtl/pwm_duty_scheduler.sv
// ============================================================================
// pwm_duty_scheduler : two-client duty arbiter with frame-aligned slew limit
// Revision 1.0
// ============================================================================
`default_nettype none

module pwm_duty_scheduler
  import pwm_duty_scheduler_pkg::*;
#(
  parameter int unsigned DUTY_W    = DEFAULT_DUTY_W,
  parameter int unsigned PERIOD    = DEFAULT_PERIOD,
  parameter int unsigned RAMP_STEP = DEFAULT_RAMP_STEP
) (
  input  logic              clk_3125KHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              estop,
  input  logic              a_valid,
  input  logic [DUTY_W-1:0] a_duty,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [DUTY_W-1:0] b_duty,
  output logic              b_ready,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              frame_start,
  output logic              busy,
  output logic              stopped
);

  localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(RAMP_STEP);

  logic              bnd;
  sched_state_e      state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W:0]   duty_ext, tgt_ext, diff, stepped;
  logic              a_acc, b_acc;

  pwm_duty_scheduler_frame_timer #(
    .PERIOD (PERIOD)
  ) u_frame_timer (
    .clk         (clk_3125KHz),
    .rst_n       (rst_n),
    .bnd         (bnd),
    .frame_start (frame_start)
  );

  always_comb begin
    b_ready = ~estop & (state_q != ST_STOP) & enable;
    a_ready = b_ready & ~b_valid;
    b_acc   = b_valid & b_ready;
    a_acc   = a_valid & a_ready;

    // One extra bit keeps the difference and the step free of wrap-around
    duty_ext = {1'b0, duty_q};
    tgt_ext  = {1'b0, target_q};
    if (tgt_ext > duty_ext) begin
      diff    = tgt_ext - duty_ext;
      stepped = duty_ext + ((diff > STEP) ? STEP : diff);
    end else begin
      diff    = duty_ext - tgt_ext;
      stepped = duty_ext - ((diff > STEP) ? STEP : diff);
    end

    target_d = target_q;
    if (!enable)    target_d = '0;
    else if (b_acc) target_d = b_duty;
    else if (a_acc) target_d = a_duty;

    duty_d  = duty_q;
    state_d = state_q;
    if (estop) begin
      state_d  = ST_STOP;
      duty_d   = '0;
      target_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (target_q != duty_q) state_d = ST_RAMP;
        // The step uses the target held before this edge's accept
        ST_RAMP: if (bnd) begin
          duty_d = stepped[DUTY_W-1:0];
          if (stepped == tgt_ext) state_d = ST_IDLE;
        end
        ST_STOP: if (bnd) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
    end
  end

  assign duty_cycle = duty_q;
  assign stopped    = (state_q == ST_STOP);
  assign busy       = (duty_q != target_q) | (state_q == ST_STOP);

endmodule

`default_nettype wire
